// File: rtl/cpu7_ifu_ibuf_pkg.sv
// Shared constants for the IFU instruction buffer: default widths, queue
// depth and the fetch-line geometry, plus a helper for line entry counts.
package cpu7_ifu_ibuf_pkg;

   localparam int CPU7_GRLEN = 32;
   localparam int IBUF_DEPTH = 8;
   localparam int INST_W     = 32;
   localparam int EX_W       = 1;
   localparam int EXCCODE_W  = 6;
   localparam int LINE_INSTS = 4;

   // Entries a fetch line occupies: an exception line collapses to one entry.
   function automatic logic [2:0] line_entries(input logic ex, input logic [1:0] count);
      return ex ? 3'd1 : ({1'b0, count} + 3'd1);
   endfunction

endpackage

// File: rtl/cpu7_ifu_ibuf_mem.sv
// Instruction buffer storage: DEPTH entries, one write port per instruction
// of a fetch line and one read port per decode slot.
module cpu7_ifu_ibuf_mem
   import cpu7_ifu_ibuf_pkg::*;
#(
   parameter int GRLEN   = CPU7_GRLEN,
   parameter int DEPTH   = IBUF_DEPTH,
   parameter int ISSUE_W = 2
) (
   input  logic                                  clock,
   input  logic [LINE_INSTS-1:0]                 wr_en,
   input  logic [LINE_INSTS*$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [LINE_INSTS*INST_W-1:0]          wr_inst,
   input  logic [LINE_INSTS*GRLEN-1:0]           wr_pc,
   input  logic [LINE_INSTS-1:0]                 wr_ex,
   input  logic [LINE_INSTS*EXCCODE_W-1:0]       wr_exccode,
   input  logic [ISSUE_W*$clog2(DEPTH)-1:0]      rd_addr,
   output logic [ISSUE_W*INST_W-1:0]             rd_inst,
   output logic [ISSUE_W*GRLEN-1:0]              rd_pc,
   output logic [ISSUE_W-1:0]                    rd_ex,
   output logic [ISSUE_W*EXCCODE_W-1:0]          rd_exccode
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [INST_W-1:0]    inst_q    [DEPTH];
   logic [GRLEN-1:0]     pc_q      [DEPTH];
   logic                 ex_q      [DEPTH];
   logic [EXCCODE_W-1:0] exccode_q [DEPTH];

   // Write every enabled line slot into its entry.
   // NOTE: the array has no reset; occupancy gates every read, so stale contents are never observed.
   always_ff @(posedge clock) begin
      for (int i = 0; i < LINE_INSTS; i++) begin
         if (wr_en[i]) begin
            inst_q[wr_addr[i*PTR_W +: PTR_W]]    <= wr_inst[i*INST_W +: INST_W];
            pc_q[wr_addr[i*PTR_W +: PTR_W]]      <= wr_pc[i*GRLEN +: GRLEN];
            ex_q[wr_addr[i*PTR_W +: PTR_W]]      <= wr_ex[i];
            exccode_q[wr_addr[i*PTR_W +: PTR_W]] <= wr_exccode[i*EXCCODE_W +: EXCCODE_W];
         end
      end
   end

   // Asynchronous read, one port per decode slot.
   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      rd_inst    = '0;
      rd_pc      = '0;
      rd_ex      = '0;
      rd_exccode = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         rd_inst[k*INST_W +: INST_W]          = inst_q[rd_addr[k*PTR_W +: PTR_W]];
         rd_pc[k*GRLEN +: GRLEN]              = pc_q[rd_addr[k*PTR_W +: PTR_W]];
         rd_ex[k]                             = ex_q[rd_addr[k*PTR_W +: PTR_W]];
         rd_exccode[k*EXCCODE_W +: EXCCODE_W] = exccode_q[rd_addr[k*PTR_W +: PTR_W]];
      end
   end

endmodule

// File: rtl/cpu7_ifu_ibuf.sv
// IFU instruction buffer: queues fetch lines (up to four instructions each)
// and presents up to ISSUE_W instructions per cycle to decode. An exception
// entry always ends the issue group it appears in.
module cpu7_ifu_ibuf
   import cpu7_ifu_ibuf_pkg::*;
#(
   parameter int GRLEN   = CPU7_GRLEN,
   parameter int DEPTH   = IBUF_DEPTH,
   parameter int ISSUE_W = 2
) (
   input  logic                            clock,
   input  logic                            resetn,
   input  logic                            fdp_ibuf_valid,
   input  logic [GRLEN-1:0]                fdp_ibuf_pc,
   input  logic [1:0]                      fdp_ibuf_count,
   input  logic [127:0]                    fdp_ibuf_rdata,
   input  logic                            fdp_ibuf_ex,
   input  logic [EXCCODE_W-1:0]            fdp_ibuf_exccode,
   output logic                            ibuf_fdp_ready,
   input  logic                            ifu_ibuf_flush,
   input  logic                            exu_ifu_stall_req,
   output logic [ISSUE_W-1:0]              ibuf_dec_valid,
   output logic [32*ISSUE_W-1:0]           ibuf_dec_inst,
   output logic [GRLEN*ISSUE_W-1:0]        ibuf_dec_pc,
   output logic [ISSUE_W-1:0]              ibuf_dec_ex,
   output logic [EXCCODE_W*ISSUE_W-1:0]    ibuf_dec_exccode,
   output logic [$clog2(DEPTH+1)-1:0]      ibuf_occ
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH+1);
   localparam logic [OCC_W-1:0] READY_MAX = OCC_W'(DEPTH - LINE_INSTS);

   logic [PTR_W-1:0] head_q, tail_q;
   logic [OCC_W-1:0] occ_q;
   logic             push_fire;
   logic [OCC_W-1:0] push_cnt, pop_cnt;

   logic [LINE_INSTS-1:0]           wr_en;
   logic [LINE_INSTS*PTR_W-1:0]     wr_addr;
   logic [LINE_INSTS*GRLEN-1:0]     wr_pc;
   logic [LINE_INSTS-1:0]           wr_ex;
   logic [LINE_INSTS*EXCCODE_W-1:0] wr_exccode;
   logic [ISSUE_W*PTR_W-1:0]        rd_addr;

   assign ibuf_occ       = occ_q;
   assign ibuf_fdp_ready = (occ_q <= READY_MAX);
   assign push_fire      = fdp_ibuf_valid & ibuf_fdp_ready & ~ifu_ibuf_flush;
   assign push_cnt       = push_fire ? OCC_W'(line_entries(fdp_ibuf_ex, fdp_ibuf_count)) : '0;

   // Spread the line over consecutive entries from the tail; PCs step by 4.
   always_comb begin
      wr_en      = '0;
      wr_addr    = '0;
      wr_pc      = '0;
      wr_ex      = '0;
      wr_exccode = '0;
      for (int i = 0; i < LINE_INSTS; i++) begin
         wr_en[i] = push_fire & (fdp_ibuf_ex ? (i == 0) : (2'(i) <= fdp_ibuf_count));
         wr_addr[i*PTR_W +: PTR_W]            = tail_q + PTR_W'(i);
         wr_pc[i*GRLEN +: GRLEN]              = fdp_ibuf_pc + GRLEN'(4 * i);
         wr_ex[i]                             = fdp_ibuf_ex;
         wr_exccode[i*EXCCODE_W +: EXCCODE_W] = fdp_ibuf_exccode;
      end
   end

   // Slot k reads entry head+k.
   always_comb begin
      rd_addr = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         rd_addr[k*PTR_W +: PTR_W] = head_q + PTR_W'(k);
      end
   end

   // Slot valid: occupied, no flush, and no exception issued in a lower slot.
   always_comb begin
      logic blocked;
      blocked        = 1'b0;
      ibuf_dec_valid = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         ibuf_dec_valid[k] = (occ_q > OCC_W'(k)) & ~ifu_ibuf_flush & ~blocked;
         if (ibuf_dec_valid[k] && ibuf_dec_ex[k]) blocked = 1'b1;
      end
   end

   // Entries consumed by decode this cycle; nothing leaves while stalled.
   always_comb begin
      pop_cnt = '0;
      if (!exu_ifu_stall_req) begin
         for (int k = 0; k < ISSUE_W; k++) begin
            if (ibuf_dec_valid[k]) pop_cnt = pop_cnt + OCC_W'(1);
         end
      end
   end

   // Pointer and occupancy update; reset and flush both empty the queue.
   // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clock) begin
      if (!resetn || ifu_ibuf_flush) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_q + PTR_W'(pop_cnt);
         tail_q <= tail_q + PTR_W'(push_cnt);
         occ_q  <= occ_q + push_cnt - pop_cnt;
      end
   end

   cpu7_ifu_ibuf_mem #(
      .GRLEN   (GRLEN),
      .DEPTH   (DEPTH),
      .ISSUE_W (ISSUE_W)
   ) u_mem (
      .clock      (clock),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_inst    (fdp_ibuf_rdata),
      .wr_pc      (wr_pc),
      .wr_ex      (wr_ex),
      .wr_exccode (wr_exccode),
      .rd_addr    (rd_addr),
      .rd_inst    (ibuf_dec_inst),
      .rd_pc      (ibuf_dec_pc),
      .rd_ex      (ibuf_dec_ex),
      .rd_exccode (ibuf_dec_exccode)
   );

endmodule

// File: tb/tb_cpu7_ifu_ibuf.sv
// Self-checking bench for cpu7_ifu_ibuf: a table of per-cycle stimulus with
// hand-derived occupancy, a queue scoreboard of expected entries, and a
// randomised tail driven against the same scoreboard.
module tb_cpu7_ifu_ibuf;

   localparam int GRLEN   = 32;
   localparam int DEPTH   = 8;
   localparam int ISSUE_W = 2;
   localparam int OCC_W   = $clog2(DEPTH+1);

   logic                         clock = 1'b0;
   logic                         resetn;
   logic                         fdp_ibuf_valid;
   logic [GRLEN-1:0]             fdp_ibuf_pc;
   logic [1:0]                   fdp_ibuf_count;
   logic [127:0]                 fdp_ibuf_rdata;
   logic                         fdp_ibuf_ex;
   logic [5:0]                   fdp_ibuf_exccode;
   logic                         ibuf_fdp_ready;
   logic                         ifu_ibuf_flush;
   logic                         exu_ifu_stall_req;
   logic [ISSUE_W-1:0]           ibuf_dec_valid;
   logic [32*ISSUE_W-1:0]        ibuf_dec_inst;
   logic [GRLEN*ISSUE_W-1:0]     ibuf_dec_pc;
   logic [ISSUE_W-1:0]           ibuf_dec_ex;
   logic [6*ISSUE_W-1:0]         ibuf_dec_exccode;
   logic [OCC_W-1:0]             ibuf_occ;

   cpu7_ifu_ibuf #(.GRLEN(GRLEN), .DEPTH(DEPTH), .ISSUE_W(ISSUE_W)) dut (
      .clock             (clock),
      .resetn            (resetn),
      .fdp_ibuf_valid    (fdp_ibuf_valid),
      .fdp_ibuf_pc       (fdp_ibuf_pc),
      .fdp_ibuf_count    (fdp_ibuf_count),
      .fdp_ibuf_rdata    (fdp_ibuf_rdata),
      .fdp_ibuf_ex       (fdp_ibuf_ex),
      .fdp_ibuf_exccode  (fdp_ibuf_exccode),
      .ibuf_fdp_ready    (ibuf_fdp_ready),
      .ifu_ibuf_flush    (ifu_ibuf_flush),
      .exu_ifu_stall_req (exu_ifu_stall_req),
      .ibuf_dec_valid    (ibuf_dec_valid),
      .ibuf_dec_inst     (ibuf_dec_inst),
      .ibuf_dec_pc       (ibuf_dec_pc),
      .ibuf_dec_ex       (ibuf_dec_ex),
      .ibuf_dec_exccode  (ibuf_dec_exccode),
      .ibuf_occ          (ibuf_occ)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        ex;
      logic [5:0]  code;
   } ent_t;

   typedef struct {
      bit          rst;
      bit          v;
      logic [31:0] pc;
      logic [1:0]  cnt;
      bit          ex;
      logic [5:0]  code;
      bit          flush;
      bit          stall;
      int          exp_occ;   // occupancy expected during this cycle, -1 = not tabulated
   } vec_t;

   ent_t model_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rdata_of(input logic [31:0] pc);
      logic [127:0] r;
      for (int i = 0; i < 4; i++) r[32*i +: 32] = pc ^ (32'h1357_2468 + 32'h0101_0101 * i);
      return r;
   endfunction

   function automatic vec_t mk(input bit rst, input bit v, input logic [31:0] pc,
                               input logic [1:0] cnt, input bit ex, input logic [5:0] code,
                               input bit flush, input bit stall, input int exp_occ);
      vec_t t;
      t.rst = rst; t.v = v; t.pc = pc; t.cnt = cnt; t.ex = ex; t.code = code;
      t.flush = flush; t.stall = stall; t.exp_occ = exp_occ;
      return t;
   endfunction

   // Drive one cycle, compare outputs against the scoreboard, then advance it.
   task automatic run_cycle(input vec_t t, input string tag);
      logic [127:0] rd;
      int  sz;
      bit  rdy;
      bit  blocked;
      bit  exp_v;
      int  npop;
      ent_t e;
      rd                = rdata_of(t.pc);
      resetn            = ~t.rst;
      fdp_ibuf_valid    = t.v;
      fdp_ibuf_pc       = t.pc;
      fdp_ibuf_count    = t.cnt;
      fdp_ibuf_rdata    = rd;
      fdp_ibuf_ex       = t.ex;
      fdp_ibuf_exccode  = t.code;
      ifu_ibuf_flush    = t.flush;
      exu_ifu_stall_req = t.stall;
      #1;
      sz  = model_q.size();
      rdy = (DEPTH - sz) >= 4;
      check({tag, " occ"}, 64'(ibuf_occ), 64'(sz));
      if (t.exp_occ >= 0) check({tag, " occ_table"}, 64'(ibuf_occ), 64'(t.exp_occ));
      check({tag, " ready"}, 64'(ibuf_fdp_ready), 64'(rdy));
      blocked = 0;
      npop    = 0;
      for (int k = 0; k < ISSUE_W; k++) begin
         exp_v = (sz > k) && !t.flush && !blocked;
         check($sformatf("%s valid%0d", tag, k), 64'(ibuf_dec_valid[k]), 64'(exp_v));
         if (exp_v) begin
            check($sformatf("%s pc%0d", tag, k),   64'(ibuf_dec_pc[k*GRLEN +: GRLEN]), 64'(model_q[k].pc));
            check($sformatf("%s inst%0d", tag, k), 64'(ibuf_dec_inst[k*32 +: 32]),   64'(model_q[k].inst));
            check($sformatf("%s ex%0d", tag, k),   64'(ibuf_dec_ex[k]),              64'(model_q[k].ex));
            if (model_q[k].ex)
               check($sformatf("%s code%0d", tag, k), 64'(ibuf_dec_exccode[k*6 +: 6]), 64'(model_q[k].code));
            if (model_q[k].ex) blocked = 1;
            npop++;
         end
      end
      if (t.rst || t.flush) begin
         model_q.delete();
      end else begin
         if (!t.stall) repeat (npop) void'(model_q.pop_front());
         if (t.v && rdy) begin
            if (t.ex) begin
               e.inst = rd[31:0]; e.pc = t.pc; e.ex = 1'b1; e.code = t.code;
               model_q.push_back(e);
            end else begin
               for (int i = 0; i <= int'(t.cnt); i++) begin
                  e.inst = rd[32*i +: 32]; e.pc = t.pc + 32'(4*i); e.ex = 1'b0; e.code = '0;
                  model_q.push_back(e);
               end
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[35];
      vec_t rv;

      // Reset sequence: queue empty, ready high, no slot valid.
      resetn = 1'b0; fdp_ibuf_valid = 0; fdp_ibuf_pc = '0; fdp_ibuf_count = '0;
      fdp_ibuf_rdata = '0; fdp_ibuf_ex = 0; fdp_ibuf_exccode = '0;
      ifu_ibuf_flush = 0; exu_ifu_stall_req = 0;
      repeat (2) @(posedge clock);
      #1;
      check("reset occ",   64'(ibuf_occ), 64'd0);
      check("reset ready", 64'(ibuf_fdp_ready), 64'd1);
      check("reset valid", 64'(ibuf_dec_valid), 64'd0);
      resetn = 1'b1;

      //          rst v  pc            cnt ex code   fl st occ
      vecs = '{
         mk(0, 1, 32'h1C00_0000, 3, 0, 6'h00, 0, 0, 0),   // line push
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 4),
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 2),
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 0),
         mk(0, 1, 32'h0000_2000, 3, 0, 6'h00, 0, 1, 0),   // fill under stall
         mk(0, 1, 32'h0000_3000, 3, 0, 6'h00, 0, 1, 4),   // wraps 7->0
         mk(0, 1, 32'h0000_4000, 3, 0, 6'h00, 0, 1, 8),   // full, dropped
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 8),
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 6),
         mk(0, 1, 32'h0000_5000, 3, 0, 6'h00, 0, 0, 4),
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 6),
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 4),
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 2),
         mk(0, 1, 32'h0000_6000, 0, 0, 6'h00, 0, 1, 0),   // one normal entry
         mk(0, 1, 32'h0000_6100, 3, 1, 6'h08, 0, 1, 1),   // exception line
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 2),
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 0),
         mk(0, 1, 32'h0000_7000, 2, 1, 6'h0A, 0, 1, 0),   // exception in slot 0
         mk(0, 1, 32'h0000_7100, 1, 0, 6'h00, 0, 1, 1),
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 3),
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 2),
         mk(0, 1, 32'h0000_8000, 3, 0, 6'h00, 0, 1, 0),   // build 6 entries
         mk(0, 1, 32'h0000_8100, 1, 0, 6'h00, 0, 1, 4),
         mk(0, 1, 32'h0000_9000, 3, 0, 6'h00, 1, 0, 6),   // flush with push
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 0),
         mk(0, 1, 32'h0000_A000, 3, 0, 6'h00, 0, 1, 0),
         mk(0, 1, 32'h0000_A100, 1, 0, 6'h00, 0, 0, 4),   // push 2 + pop 2
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 4),
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 2),
         mk(0, 1, 32'hFFFF_FFF8, 3, 0, 6'h00, 0, 0, 0),   // pc wrap
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 4),
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 2),
         mk(0, 1, 32'h0000_B000, 3, 0, 6'h00, 0, 1, 0),
         mk(1, 1, 32'h0000_B100, 3, 0, 6'h00, 0, 0, 4),   // reset during push
         mk(0, 0, 32'h0,         0, 0, 6'h00, 0, 0, 0)
      };

      for (int i = 0; i < 35; i++) run_cycle(vecs[i], $sformatf("vec%0d", i));

      // Randomised traffic against the same scoreboard.
      for (int i = 0; i < 400; i++) begin
         rv = mk(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC,
                 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), 6'($urandom_range(0, 63)),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0), -1);
         run_cycle(rv, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
